moving_avg_filter: RTL and testbench
====================================

# moving_avg_filter

Parametrised N-tap moving-average filter for the audio sample path, successor to the single-stage delay/divide-by-8 element. Each accepted sample enters a circular delay line. A running sum is updated incrementally, adding the new sample and subtracting the sample leaving the window. The registered output is the window sum divided by N. It sits between the audio CODEC input interface and the output mixer, one instance per channel.

## Interface
- `DATA_W`, 24 — signed sample width.
- `LOG2_N`, 3 — log2 of window depth; N = 2**LOG2_N, legal range 1..8.
- `Clock`  input  1 — sole clock; all state changes on rising edge.
- `Reset`  input  1 — synchronous, active-high reset.
- `enable`  input  1 — sample strobe; `D` is accepted on a rising edge with `enable`=1.
- `D`  input  DATA_W (signed) — input sample.
- `Q`  output  DATA_W (signed) — filtered sample, registered.
- `valid`  output  1 — one-cycle pulse; `Q` updated this cycle.
- `full`  output  1 — window holds N real samples since reset.

## Operation
- Accumulator `acc` is signed, width DATA_W+LOG2_N, so it never overflows.
- Write pointer `wptr` is LOG2_N bits and wraps N-1 → 0 without a flag.
- Fill counter `cnt` is LOG2_N+1 bits and saturates at N. `full` = (cnt == N).
- On accepted sample:
  - `old` = delay_line[wptr] if `full`, else 0. Stale memory contents are never subtracted, so the delay line needs no reset.
  - `acc_next` = acc + D − old.
  - delay_line[wptr] ← D; wptr ← wptr+1; cnt ← min(cnt+1, N); acc ← acc_next.
  - Q ← acc_next / N, signed, truncated toward zero. The result always fits in DATA_W.
- Before the window fills, missing taps count as zero, so the output ramps up from zero.
- `enable`=0: all state holds, `valid`=0, `Q` holds its last value.
- `Reset`=1 takes priority over `enable` in the same cycle.
  - acc, wptr, cnt, Q, valid, full ← 0.
  - Delay line contents are left undefined.

## Timing
- Latency is 1 cycle: a sample accepted at edge k gives `Q`, `valid`=1 and the updated `full` after edge k.
- Back-to-back `enable` every cycle is supported at full throughput.
- `valid` is high for exactly the cycles following accepted edges.
- `full` rises after the edge that accepts the Nth sample following reset.
- Reset mid-operation: `Q`=0 after the reset edge. The next sample restarts the ramp from an empty window.

## Configuration
- `MOVING_AVG_ROUND_EN`
  - Defined: Q ← (acc_next + (acc_next<0 ? −N/2 : N/2)) / N, truncated. This rounds half away from zero.
  - Undefined: plain truncation toward zero.
  - Rounded results never exceed the DATA_W range, because |acc_next| ≤ N·2^(DATA_W−1).

## Structure
- Package `moving_avg_pkg` holds:
  - `sample_t` (signed DATA_W) and `acc_t` (signed DATA_W+LOG2_N) typedefs, parameterised through package localparams matching the defaults.
  - Function `avg_div(acc_t, int log2n)` implementing truncating/rounding division. The macro is honoured in this function.
- Sub-module `avg_delay_line`:
  - N×DATA_W circular buffer.
  - Read of the current `wptr` entry before write, in the same edge.
  - Inferable as registers or RAM.
- Top-level `moving_avg_filter` holds acc, cnt, the Q register and the control logic.

## Test plan
Default parameters (N=8, DATA_W=24) unless noted.
- **Reset:** assert `Reset` with `enable`=1 and D=100 → Q=0, valid=0, full=0 next cycle. Acc stays 0 and the sample is not taken.
- **Positive ramp:**
  - Eight accepted samples of 128 → Q = 16, 32, …, 128.
  - `full` rises with the 8th.
  - A 9th sample of 0 → Q=112.
- **Sign and truncation:**
  - After reset, one sample of −1 → Q=0.
  - Seven more samples of −1 → Q=−1 on the 8th.
  - With `MOVING_AVG_ROUND_EN`: a single sample of −4 → Q=−1, and a single 12 → Q=2.
- **Hold:** `enable`=0 for 5 cycles while D toggles 0x7FFFFF/0x800000 → Q unchanged, valid=0 throughout.
- **Extremes:**
  - Eight samples of 0x7FFFFF → Q=0x7FFFFF.
  - Then eight samples of 0x800000 → Q=0x800000, with no wrap at any step.
- **Reset mid-stream:** after 5 samples of 1000, pulse `Reset`, then feed eight samples of 8 → Q = 1, 2, …, 8. No stale 1000 is subtracted, and `full` rises on the 8th.

Source files
------------

// File: rtl/moving_avg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : moving_avg_pkg
//  Description : Shared types and the window-sum divider for the N-tap
//                moving-average filter.
//                sample_t : signed PKG_DATA_W audio sample
//                acc_t    : signed PKG_DATA_W+PKG_LOG2_N window sum
//                avg_div  : divide a window sum by 2**log2n
//  Options     : MOVING_AVG_ROUND_EN -- when defined, avg_div rounds half
//                away from zero; otherwise it truncates toward zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package moving_avg_pkg;

  localparam int PKG_DATA_W = 24;
  localparam int PKG_LOG2_N = 3;
  localparam int PKG_ACC_W  = PKG_DATA_W + PKG_LOG2_N;

  typedef logic signed [PKG_DATA_W-1:0] sample_t;
  typedef logic signed [PKG_ACC_W-1:0]  acc_t;

  // Signed divide by 2**log2n. Work one bit wider than acc_t so the rounding
  // bias cannot overflow at the most negative window sum.
  function automatic acc_t avg_div(acc_t a, int log2n);
    logic signed [PKG_ACC_W:0] x;
    logic signed [PKG_ACC_W:0] m;
    x = {a[PKG_ACC_W-1], a};
`ifdef MOVING_AVG_ROUND_EN
    if (log2n > 0) begin
      m = (PKG_ACC_W+1)'(1) << (log2n - 1);
      x = (x < 0) ? x - m : x + m;
    end
`endif
    // Arithmetic shift floors; adding (2**log2n - 1) to negatives first
    // turns that into truncation toward zero.
    m = ~({(PKG_ACC_W+1){1'b1}} << log2n);
    if (x < 0) begin
      x = x + m;
    end
    x = x >>> log2n;
    return x[PKG_ACC_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/avg_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : avg_delay_line
//  Description : N x DATA_W circular sample buffer. The entry at addr_i is
//                read combinationally, so the value leaving the window is
//                available in the same cycle that the new sample overwrites
//                it on the rising edge. No reset: contents are only used once
//                the window has been refilled.
//  Ports       : clk_i   - clock
//                we_i    - write strobe
//                addr_i  - read/write address (write pointer)
//                wdata_i - sample to store
//                rdata_o - current contents of addr_i (pre-write)
//  Revision    : 1.0 - initial release
// ============================================================================
module avg_delay_line #(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [LOG2_N-1:0]        addr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  output logic signed [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << LOG2_N;

  logic signed [DATA_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/moving_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module      : moving_avg_filter
//  Description : N-tap (N = 2**LOG2_N) moving-average filter with a running
//                sum. Each accepted sample is added to the sum and the sample
//                leaving the window is subtracted; until the window is full
//                the missing taps count as zero, so the output ramps up.
//  Ports       : Clock  - clock
//                Reset  - synchronous active-high reset (wins over enable)
//                enable - sample strobe, D accepted on the rising edge
//                D      - signed input sample
//                Q      - registered window average
//                valid  - one-cycle pulse, Q updated this cycle
//                full   - window holds N samples since reset
//  Options     : MOVING_AVG_ROUND_EN -- round half away from zero instead of
//                truncating toward zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module moving_avg_filter
  import moving_avg_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int LOG2_N = 3
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] D,
  output logic signed [DATA_W-1:0] Q,
  output logic                     valid,
  output logic                     full
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam logic [LOG2_N:0] N_CNT = (LOG2_N+1)'(1 << LOG2_N);

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0]        wptr_q, wptr_d;
  logic [LOG2_N:0]          cnt_q, cnt_d;
  logic signed [DATA_W-1:0] q_q, q_d;
  logic                     valid_q;
  logic                     full_w;
  logic signed [DATA_W-1:0] old_w;
  logic signed [DATA_W-1:0] rd_w;
  logic signed [ACC_W-1:0]  div_w;

  avg_delay_line #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_delay_line (
    .clk_i   (Clock),
    .we_i    (enable & ~Reset),
    .addr_i  (wptr_q),
    .wdata_i (D),
    .rdata_o (rd_w)
  );

  assign full_w = (cnt_q == N_CNT);

  // Until the window is full the slot being overwritten holds stale data.
  assign old_w  = full_w ? rd_w : '0;
  assign acc_d  = acc_q + ACC_W'(D) - ACC_W'(old_w);
  assign wptr_d = wptr_q + LOG2_N'(1);
  assign cnt_d  = full_w ? cnt_q : cnt_q + (LOG2_N+1)'(1);

  // The package divider is sized for the default configuration; other
  // widths use an equivalent local divider.
  if ((DATA_W == PKG_DATA_W) && (LOG2_N == PKG_LOG2_N)) begin : g_pkg_div
    assign div_w = avg_div(acc_d, LOG2_N);
  end else begin : g_local_div
    logic signed [ACC_W:0] ext_w;
    logic signed [ACC_W:0] bias_w;
    logic signed [ACC_W:0] mask_w;
    logic signed [ACC_W:0] res_w;
    always_comb begin
      ext_w  = {acc_d[ACC_W-1], acc_d};
      bias_w = '0;
`ifdef MOVING_AVG_ROUND_EN
      bias_w = (ACC_W+1)'(1) << (LOG2_N - 1);
      ext_w  = (ext_w < 0) ? ext_w - bias_w : ext_w + bias_w;
`endif
      mask_w = ~({(ACC_W+1){1'b1}} << LOG2_N);
      res_w  = (ext_w < 0) ? ext_w + mask_w : ext_w;
      res_w  = res_w >>> LOG2_N;
    end
    assign div_w = res_w[ACC_W-1:0];
  end

  // |acc| <= N * 2**(DATA_W-1), so the quotient always fits in DATA_W.
  assign q_d = div_w[DATA_W-1:0];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_q   <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= enable;
      if (enable) begin
        acc_q  <= acc_d;
        wptr_q <= wptr_d;
        cnt_q  <= cnt_d;
        q_q    <= q_d;
      end
    end
  end

  assign Q     = q_q;
  assign valid = valid_q;
  assign full  = full_w;

endmodule
`default_nettype wire

// File: tb/tb_moving_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_moving_avg_filter
//  Description : Directed self-checking bench for moving_avg_filter with
//                default parameters (N = 8, DATA_W = 24).
//  Options     : MOVING_AVG_ROUND_EN -- adds rounding vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_moving_avg_filter;

  logic               Clock;
  logic               Reset;
  logic               enable;
  logic signed [23:0] D;
  logic signed [23:0] Q;
  logic               valid;
  logic               full;

  int checks = 0;
  int errors = 0;

  moving_avg_filter #(
    .DATA_W (24),
    .LOG2_N (3)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (enable),
    .D      (D),
    .Q      (Q),
    .valid  (valid),
    .full   (full)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Drive one cycle of stimulus at the falling edge, sample 1 time unit
  // after the following rising edge.
  task automatic step(input logic en, input int d);
    @(negedge Clock);
    Reset  = 1'b0;
    enable = en;
    D      = 24'(d);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset  = 1'b1;
    enable = 1'b0;
    @(posedge Clock);
    #1;
    Reset  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clock);
    Reset  = 1'b1;
    enable = 1'b1;
    D      = 24'sd100;
    @(posedge Clock);
    #1;
    checks++;
    if (Q !== 24'sd0 || valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Q=%0d valid=%b full=%b, expected Q=0 valid=0 full=0", Q, valid, full);
    end
    Reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_ramp();
    int exp_q;
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 128);
      exp_q = 16 * k;
      checks++;
      if (Q !== 24'(exp_q) || valid !== 1'b1 || full !== (k == 8)) begin
        errors++;
        $display("FAIL ramp step %0d: Q=%0d valid=%b full=%b, expected Q=%0d valid=1 full=%b",
                 k, Q, valid, full, exp_q, (k == 8));
      end
    end
    step(1'b1, 0);
    checks++;
    if (Q !== 24'sd112 || full !== 1'b1) begin
      errors++;
      $display("FAIL ramp_ninth: Q=%0d full=%b, expected Q=112 full=1", Q, full);
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 5; k++) begin
      step(1'b0, (k % 2 == 0) ? 32'h7FFFFF : 32'h800000);
      checks++;
      if (Q !== 24'sd112 || valid !== 1'b0 || full !== 1'b1) begin
        errors++;
        $display("FAIL hold cycle %0d: Q=%0d valid=%b full=%b, expected Q=112 valid=0 full=1",
                 k, Q, valid, full);
      end
    end
  endtask

  task automatic test_sign_trunc();
    do_reset();
    step(1'b1, -1);
    checks++;
    if (Q !== 24'sd0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL neg_first: Q=%0d valid=%b, expected Q=0 valid=1", Q, valid);
    end
    for (int k = 2; k <= 8; k++) step(1'b1, -1);
    checks++;
    if (Q !== -24'sd1 || full !== 1'b1) begin
      errors++;
      $display("FAIL neg_eighth: Q=%0d full=%b, expected Q=-1 full=1", Q, full);
    end
  endtask

`ifdef MOVING_AVG_ROUND_EN
  task automatic test_rounding();
    do_reset();
    step(1'b1, -4);
    checks++;
    if (Q !== -24'sd1) begin
      errors++;
      $display("FAIL round_neg4: Q=%0d, expected -1", Q);
    end
    do_reset();
    step(1'b1, 12);
    checks++;
    if (Q !== 24'sd2) begin
      errors++;
      $display("FAIL round_pos12: Q=%0d, expected 2", Q);
    end
  endtask
`endif

  task automatic test_extremes();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 32'h7FFFFF);
      checks++;
      if (Q <= 24'sd0) begin
        errors++;
        $display("FAIL max_ramp step %0d: Q=%0d, expected positive", k, Q);
      end
    end
    checks++;
    if (Q !== 24'sh7FFFFF) begin
      errors++;
      $display("FAIL max_full: Q=%h, expected 7fffff", Q);
    end
    // Sum walks from +8*max down to -8*2**23; sign flips only after the
    // fourth negative sample (sum -4 at step 4).
    for (int j = 1; j <= 8; j++) begin
      step(1'b1, 32'hFF800000);
      if (j <= 3) begin
        checks++;
        if (Q <= 24'sd0) begin
          errors++;
          $display("FAIL min_walk step %0d: Q=%0d, expected positive", j, Q);
        end
      end else if (j >= 5) begin
        checks++;
        if (Q >= 24'sd0) begin
          errors++;
          $display("FAIL min_walk step %0d: Q=%0d, expected negative", j, Q);
        end
      end
    end
    checks++;
    if (Q !== 24'sh800000) begin
      errors++;
      $display("FAIL min_full: Q=%h, expected 800000", Q);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1000);
    checks++;
    if (Q !== 24'sd625) begin
      errors++;
      $display("FAIL mid_prefill: Q=%0d, expected 625", Q);
    end
    do_reset();
    checks++;
    if (Q !== 24'sd0 || full !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: Q=%0d full=%b valid=%b, expected 0 0 0", Q, full, valid);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 8);
      checks++;
      if (Q !== 24'(k) || full !== (k == 8)) begin
        errors++;
        $display("FAIL mid_ramp step %0d: Q=%0d full=%b, expected Q=%0d full=%b",
                 k, Q, full, k, (k == 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    // Continue from a full window of 8s: a stream of 16s replaces one tap
    // per cycle, raising the average by exactly 1 each cycle.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 16);
      checks++;
      if (Q !== 24'(8 + k) || valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b step %0d: Q=%0d valid=%b, expected Q=%0d valid=1", k, Q, valid, 8 + k);
      end
    end
    step(1'b0, 0);
    checks++;
    if (valid !== 1'b0 || Q !== 24'sd16) begin
      errors++;
      $display("FAIL b2b_idle: Q=%0d valid=%b, expected Q=16 valid=0", Q, valid);
    end
  endtask

  initial begin
    Reset  = 1'b1;
    enable = 1'b0;
    D      = '0;
    repeat (2) @(posedge Clock);
    test_reset();
    test_ramp();
    test_hold();
    test_sign_trunc();
`ifdef MOVING_AVG_ROUND_EN
    test_rounding();
`endif
    test_extremes();
    test_reset_midstream();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
